// File: rtl/mem_access_ctrl.sv
// Data-memory access controller for the MEM stage: holds the pipeline while one
// word access to a handshaked external memory completes, times out, or is rejected.
module mem_access_ctrl #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [31:0] rdata_o,
   output logic        stall_o,
   output logic        done_o,
   output logic        err_o
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q;
   logic        we_q;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic        err_q;

   logic req, misalign, timeout;

   assign req      = MemRead_i | MemWrite_i;
   assign misalign = addr_i[1:0] != 2'b00;
   assign timeout  = cnt_q == 4'(TIMEOUT - 1);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Outputs decode straight from the state so a reset drops them without a clock edge.
   always_comb begin
      state_d   = state_q;
      stall_o   = 1'b0;
      mem_req_o = 1'b0;
      mem_we_o  = 1'b0;
      done_o    = 1'b0;
      case (state_q)
         IDLE: begin
            stall_o = req;
            if (req) state_d = misalign ? DONE : ACCESS;
         end
         ACCESS: begin
            stall_o   = 1'b1;
            mem_req_o = 1'b1;
            mem_we_o  = we_q;
            if (mem_ack_i || timeout) state_d = DONE;
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A simultaneous read+write request is executed as a store but still flagged.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (req) begin
               if (MemRead_i && MemWrite_i) err_q <= 1'b1;
               if (misalign) begin
                  err_q <= 1'b1;
                  if (!MemWrite_i) rdata_q <= '0;
               end else begin
                  addr_q  <= addr_i;
                  wdata_q <= wdata_i;
                  we_q    <= MemWrite_i;
                  cnt_q   <= '0;
               end
            end
            ACCESS: begin
               cnt_q <= cnt_q + 4'd1;
               if (mem_ack_i) begin
                  if (!we_q) rdata_q <= mem_rdata_i;
               end else if (timeout) begin
                  err_q <= 1'b1;
                  if (!we_q) rdata_q <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign rdata_o     = rdata_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Transaction-level bench for mem_access_ctrl: each access is planned up front
// (ack cycle or timeout) and the expected per-cycle outputs follow from that plan.
module tb_mem_access_ctrl;
   localparam int TIMEOUT = 15;

   logic        clk = 1'b0, rst_i = 1'b0;
   logic        MemRead_i = 1'b0, MemWrite_i = 1'b0, mem_ack_i = 1'b0;
   logic [31:0] addr_i = '0, wdata_i = '0, mem_rdata_i = '0;
   logic        mem_req_o, mem_we_o, stall_o, done_o, err_o;
   logic [31:0] mem_addr_o, mem_wdata_o, rdata_o;

   mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk), .rst_i(rst_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .rdata_o(rdata_o), .stall_o(stall_o),
      .done_o(done_o), .err_o(err_o));

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int stall_cnt, req_cnt, done_cnt;
   bit chk_en = 1'b0;
   logic        e_stall, e_req, e_we, e_done, e_err;
   logic [31:0] e_rdata, e_addr, e_wdata;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic clear_model();
      e_stall = 0; e_req = 0; e_we = 0; e_done = 0; e_err = 0;
      e_rdata = '0; e_addr = '0; e_wdata = '0;
   endtask

   // Per-cycle compare against the model, sampled on the falling edge.
   task automatic step();
      @(negedge clk);
      if (stall_o)   stall_cnt++;
      if (mem_req_o) req_cnt++;
      if (done_o)    done_cnt++;
      if (chk_en) begin
         chk("stall_o", stall_o, e_stall);
         chk("mem_req_o", mem_req_o, e_req);
         chk("mem_we_o", mem_we_o, e_we);
         chk("done_o", done_o, e_done);
         chk("err_o", err_o, e_err);
         chk("rdata_o", rdata_o, e_rdata);
         chk("mem_addr_o", mem_addr_o, e_addr);
         chk("mem_wdata_o", mem_wdata_o, e_wdata);
      end
   endtask

   // ackn: ACCESS cycle carrying the ack (1..TIMEOUT); anything else means no ack.
   task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input int ackn, input logic [31:0] rdv);
      bit mis, tmo;
      int n, len;
      mis = a[1:0] != 2'b00;
      tmo = !mis && (ackn < 1 || ackn > TIMEOUT);
      n   = tmo ? TIMEOUT : ackn;
      len = mis ? 1 : n + 1;
      stall_cnt = 0; req_cnt = 0; done_cnt = 0;
      for (int k = 0; k <= len; k++) begin
         @(posedge clk); #1;
         MemRead_i = rd; MemWrite_i = wr; addr_i = a; wdata_i = wd;
         if (!mis && k >= 1 && k < len) mem_ack_i = (k == n) && !tmo;
         else mem_ack_i = 1'($urandom_range(0, 1));
         mem_rdata_i = (!mis && !tmo && k == n) ? rdv : $urandom;
         e_stall = k < len;
         e_req   = !mis && k >= 1 && k < len;
         e_we    = e_req && wr;
         e_done  = k == len;
         if (!mis && k == 1) begin e_addr = a; e_wdata = wd; end
         if (k == len) begin
            if (rd && !wr) e_rdata = (mis || tmo) ? 32'd0 : rdv;
            if (mis || tmo || (rd && wr)) e_err = 1'b1;
         end
         step();
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         MemRead_i = 0; MemWrite_i = 0; addr_i = $urandom; wdata_i = $urandom;
         mem_ack_i = 1'($urandom_range(0, 1)); mem_rdata_i = $urandom;
         e_stall = 0; e_req = 0; e_we = 0; e_done = 0;
         step();
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst_i = 0; MemRead_i = 0; MemWrite_i = 0; mem_ack_i = 0;
      #1;
      chk("rst mem_req_o", mem_req_o, 0);
      chk("rst stall_o", stall_o, 0);
      chk("rst err_o", err_o, 0);
      chk("rst rdata_o", rdata_o, 0);
      chk("rst mem_addr_o", mem_addr_o, 0);
      clear_model();
      @(posedge clk); #2;
      rst_i = 1;
   endtask

   initial begin
      int r, ackn;
      logic rd, wr;
      logic [31:0] a;
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      chk("reset done_o", done_o, 0);
      chk("reset mem_req_o", mem_req_o, 0);
      chk("reset mem_we_o", mem_we_o, 0);
      chk("reset rdata_o", rdata_o, 0);
      chk("reset err_o", err_o, 0);
      #1 rst_i = 1;
      chk_en = 1;

      // Aligned load, ack in 3rd ACCESS cycle.
      txn(1, 0, 32'h10, 32'h0, 3, 32'hDEADBEEF);
      chk("load stall cycles", stall_cnt, 4);
      chk("load done pulses", done_cnt, 1);
      chk("load rdata_o", rdata_o, 32'hDEADBEEF);
      chk("load err_o", err_o, 0);

      // Aligned store, ack in 1st ACCESS cycle.
      idle(2);
      txn(0, 1, 32'h20, 32'h12345678, 1, 32'h0);
      chk("store stall cycles", stall_cnt, 2);
      chk("store mem_wdata_o", mem_wdata_o, 32'h12345678);
      chk("store mem_addr_o", mem_addr_o, 32'h20);
      chk("store rdata_o kept", rdata_o, 32'hDEADBEEF);

      // Back-to-back loads; request held through DONE must not retrigger.
      txn(1, 0, 32'h100, 32'h0, 2, 32'h11111111);
      txn(1, 0, 32'h104, 32'h0, 1, 32'h22222222);
      chk("b2b done pulses", done_cnt, 1);
      chk("b2b rdata_o", rdata_o, 32'h22222222);
      idle(1);

      // Reset in 2nd ACCESS cycle, ack the following cycle.
      chk_en = 0;
      @(posedge clk); #1;
      MemRead_i = 1; addr_i = 32'h40; mem_ack_i = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre-reset mem_req_o", mem_req_o, 1);
      #2 rst_i = 0; MemRead_i = 0;
      #1;
      chk("async mem_req_o", mem_req_o, 0);
      chk("async stall_o", stall_o, 0);
      chk("async rdata_o", rdata_o, 0);
      done_cnt = 0; req_cnt = 0;
      @(posedge clk); #1;
      mem_ack_i = 1; mem_rdata_i = 32'hCAFEF00D;
      @(posedge clk); #1;
      mem_ack_i = 0; rst_i = 1;
      clear_model();
      chk_en = 1;
      step();
      idle(3);
      chk("post-reset done pulses", done_cnt, 0);
      chk("post-reset req cycles", req_cnt, 0);
      chk("post-reset rdata_o", rdata_o, 0);

      // Ack on the last permitted cycle wins over timeout.
      txn(1, 0, 32'h300, 32'h0, TIMEOUT, 32'h0BADF00D);
      chk("late-ack stall cycles", stall_cnt, 16);
      chk("late-ack err_o", err_o, 0);
      chk("late-ack rdata_o", rdata_o, 32'h0BADF00D);

      // No ack: timeout.
      txn(1, 0, 32'h200, 32'h0, 0, 32'h0);
      chk("timeout req cycles", req_cnt, 15);
      chk("timeout stall cycles", stall_cnt, 16);
      chk("timeout err_o", err_o, 1);
      chk("timeout rdata_o", rdata_o, 0);
      idle(2);
      chk("timeout mem_req_o after", mem_req_o, 0);

      // Misaligned load after a fresh reset.
      do_reset();
      txn(1, 0, 32'h30, 32'h0, 1, 32'hA5A5A5A5);
      txn(1, 0, 32'h13, 32'h0, 1, 32'h0);
      chk("misalign req cycles", req_cnt, 0);
      chk("misalign stall cycles", stall_cnt, 1);
      chk("misalign rdata_o", rdata_o, 0);
      chk("misalign err_o", err_o, 1);

      // Randomized traffic, including a fresh reset to exercise err_o clean paths.
      do_reset();
      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 3);
         rd = (r != 1);
         wr = (r == 1 || r == 2);
         if (i < 40 && r == 2) begin rd = 1; wr = 0; end
         a = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
         ackn = ($urandom_range(0, 5) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2)
                                            : $urandom_range(1, 4);
         txn(rd, wr, a, $urandom, ackn, $urandom);
         idle($urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum number of ACCESS-state cycles waited for mem_ack_i (legal range 2..15).
REQ-002 The block SHALL have port clk_i  input  1  the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port MemRead_i  input  1  load request from the EX/MEM register.
REQ-005 The block SHALL have port MemWrite_i  input  1  store request from the EX/MEM register.
REQ-006 The block SHALL have port addr_i  input  32  byte address (EX/MEM ALU result).
REQ-007 The block SHALL have port wdata_i  input  32  store data (EX/MEM regB).
REQ-008 The block SHALL have port mem_ack_i  input  1  external memory completion strobe.
REQ-009 The block SHALL have port mem_rdata_i  input  32  external memory read data, valid with mem_ack_i.
REQ-010 The block SHALL have port mem_req_o  output  1  external memory request.
REQ-011 The block SHALL have port mem_we_o  output  1  external write enable (1 = store).
REQ-012 The block SHALL have port mem_addr_o  output  32  latched word address.
REQ-013 The block SHALL have port mem_wdata_o  output  32  latched store data.
REQ-014 The block SHALL have port rdata_o  output  32  load result toward MEM/WB.
REQ-015 The block SHALL have port stall_o  output  1  pipeline hold to EX/MEM and upstream registers.
REQ-016 The block SHALL have port done_o  output  1  one-cycle access-complete pulse.
REQ-017 The block SHALL have port err_o  output  1  sticky error flag (misalign, timeout, conflict).

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS, DONE; the only transitions are those in REQ-019..REQ-025.
REQ-019 In IDLE, req = MemRead_i | MemWrite_i; stall_o SHALL be combinationally high in the same cycle req is high, so EX/MEM holds.
REQ-020 IDLE with req and addr_i[1:0]==0 SHALL latch addr_i, wdata_i and we = MemWrite_i, clear the wait counter, and go to ACCESS.
REQ-021 IDLE with req and addr_i[1:0]!=0 SHALL set err_o, load rdata_o = 0 on a load, issue no memory request, and go to DONE.
REQ-022 MemRead_i and MemWrite_i both high in IDLE SHALL be treated as a store and SHALL set err_o.
REQ-023 In ACCESS, mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o SHALL be held stable and stall_o held high; the counter increments each cycle.
REQ-024 In ACCESS, mem_ack_i sampled high SHALL go to DONE and, on a load, capture mem_rdata_i into rdata_o; ack takes priority over timeout on the same edge.
REQ-025 In ACCESS with the counter == TIMEOUT-1 and no ack, the block SHALL go to DONE, set err_o, and load rdata_o = 0 on a load.
REQ-026 In DONE, stall_o SHALL be low and done_o high for exactly one cycle; the next state SHALL be IDLE unconditionally, and req is not re-sampled in DONE.
REQ-027 mem_req_o SHALL be high only in ACCESS; mem_ack_i outside ACCESS SHALL be ignored.
REQ-028 rdata_o SHALL hold its value until the next load completes; stores SHALL not modify rdata_o.
REQ-029 Latency: an aligned access whose ack arrives in the N-th ACCESS cycle (N>=1) SHALL stall for N+1 cycles, followed by one DONE cycle.
REQ-030 err_o SHALL be sticky and cleared only by reset.

Reset
REQ-031 While rst_i is low, the state SHALL be IDLE, the counter 0, and all outputs 0 (stall_o 0 as long as req is low), taking effect immediately without a clock edge.
REQ-032 Reset asserted during ACCESS SHALL drop mem_req_o asynchronously; a later ack SHALL be ignored.

Verification
REQ-033 Aligned load: addr_i=0x0000_0010, MemRead_i=1, ack in the 3rd ACCESS cycle with mem_rdata_i=0xDEAD_BEEF -> stall_o high for 4 cycles, then done_o pulses, rdata_o=0xDEADBEEF, err_o=0.
REQ-034 Aligned store: addr_i=0x20, wdata_i=0x1234_5678, ack in the 1st ACCESS cycle -> mem_we_o=1, mem_wdata_o=0x12345678, stall_o high for 2 cycles, rdata_o unchanged.
REQ-035 Misaligned load at addr_i=0x0000_0013 -> mem_req_o never high, 1 stall cycle, DONE, rdata_o=0, err_o=1.
REQ-036 No ack with TIMEOUT=15 -> exactly 15 ACCESS cycles, then DONE, err_o=1, mem_req_o low afterward.
REQ-037 rst_i low in the 2nd ACCESS cycle, ack the following cycle -> mem_req_o falls without a clock edge, state IDLE, rdata_o=0, done_o never pulses.
REQ-038 Back-to-back loads (new load presented the cycle after DONE) -> two independent accesses, and the DONE cycle does not retrigger.
